// File: rtl/logic_exec_if.sv
// logic_exec_if.sv - handshake bundle for the logic execute stage
// Upstream side: in_valid/in_ready with in_op, in_a, in_b, in_tag.
// Downstream side: out_valid/out_ready with out_result, out_zero, out_tag.
// The slave modport is the stage itself; the master modport is the surrounding
// pipeline (the issue logic upstream and the writeback mux downstream).
interface logic_exec_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_tag
    );
endinterface

// File: rtl/logic_exec_stage.sv
// logic_exec_stage.sv - 16-bit AND/OR/XOR/ANDN execute stage with 2-entry skid buffer
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    logic_exec_if.slave
//            in_valid/in_ready (registered), in_op, in_a, in_b, in_tag
//            out_valid/out_ready, out_result, out_zero, out_tag
// in_op: 00 AND, 01 OR, 10 XOR, 11 ANDN (A & ~B).
module logic_exec_stage #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    logic_exec_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rdy_q;
    logic             acc;
    logic             pop;
    logic [WIDTH-1:0] new_result;
    logic             new_zero;

    logic [WIDTH-1:0] head_result;
    logic             head_zero;
    logic [TAG_W-1:0] head_tag;
    logic [WIDTH-1:0] skid_result;
    logic             skid_zero;
    logic [TAG_W-1:0] skid_tag;

    // rdy_q mirrors (state != FULL) but is its own flop so that it can be
    // forced low during reset while the state register sits at EMPTY.
    assign acc = bus.in_valid & rdy_q;
    assign pop = (state_q != EMPTY) & bus.out_ready;

    always_comb begin
        new_result = '0;
        case (bus.in_op)
            2'b00:   new_result = bus.in_a & bus.in_b;
            2'b01:   new_result = bus.in_a | bus.in_b;
            2'b10:   new_result = bus.in_a ^ bus.in_b;
            default: new_result = bus.in_a & ~bus.in_b;
        endcase
    end

    assign new_zero = (new_result == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (acc) state_d = ONE;
            ONE: begin
                if (acc && !pop)      state_d = FULL;
                else if (pop && !acc) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != FULL);
        end
    end

    // The head entry always drives the outputs; the skid entry only holds the
    // second op while the head is stalled. In ONE with accept and pop together
    // the new op bypasses the skid slot straight into the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_result <= '0;
            head_zero   <= 1'b0;
            head_tag    <= '0;
            skid_result <= '0;
            skid_zero   <= 1'b0;
            skid_tag    <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        head_result <= new_result;
                        head_zero   <= new_zero;
                        head_tag    <= bus.in_tag;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        head_result <= new_result;
                        head_zero   <= new_zero;
                        head_tag    <= bus.in_tag;
                    end else if (acc) begin
                        skid_result <= new_result;
                        skid_zero   <= new_zero;
                        skid_tag    <= bus.in_tag;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_result <= skid_result;
                        head_zero   <= skid_zero;
                        head_tag    <= skid_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = rdy_q;
    assign bus.out_valid  = (state_q != EMPTY);
    assign bus.out_result = head_result;
    assign bus.out_zero   = head_zero;
    assign bus.out_tag    = head_tag;
endmodule

// File: tb/tb_logic_exec_stage.sv
// tb/tb_logic_exec_stage.sv - randomized bench for logic_exec_stage against a queue model
module tb_logic_exec_stage;
    logic clk;
    logic rst_n;

    logic_exec_if #(.WIDTH(16), .TAG_W(3)) bus ();

    logic_exec_stage #(.WIDTH(16), .TAG_W(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        zero;
        logic [2:0]  tag;
    } ent_t;

    ent_t q[$];
    bit   m_rst;
    bit   armed;
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic ent_t model_op(input logic [1:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [2:0] tg);
        ent_t e;
        case (op)
            2'd0:    e.res = a & b;
            2'd1:    e.res = a | b;
            2'd2:    e.res = a ^ b;
            default: e.res = a & ~b;
        endcase
        e.zero = (e.res == 16'h0);
        e.tag  = tg;
        return e;
    endfunction

    // Called just after a falling edge: checks what the previous rising edge
    // produced, drives the next inputs and advances the model one cycle.
    task automatic step(input bit r, input bit v, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] tg, input bit ordy, output bit accepted);
        bit   exp_valid;
        bit   exp_ready;
        bit   pop;
        exp_valid = !m_rst && (q.size() > 0);
        exp_ready = !m_rst && (q.size() < 2);
        if (armed) begin
            check("out_valid", {31'h0, bus.out_valid}, {31'h0, exp_valid});
            check("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_ready});
            if (m_rst) begin
                check("rst_result", {16'h0, bus.out_result}, 32'h0);
                check("rst_zero", {31'h0, bus.out_zero}, 32'h0);
                check("rst_tag", {29'h0, bus.out_tag}, 32'h0);
            end else if (exp_valid) begin
                check("out_result", {16'h0, bus.out_result}, {16'h0, q[0].res});
                check("out_zero", {31'h0, bus.out_zero}, {31'h0, q[0].zero});
                check("out_tag", {29'h0, bus.out_tag}, {29'h0, q[0].tag});
            end
        end
        rst_n         = r;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tg;
        bus.out_ready = ordy;
        accepted = 1'b0;
        if (!r) begin
            q.delete();
            m_rst = 1'b1;
        end else begin
            accepted = v && exp_ready;
            pop      = exp_valid && ordy;
            if (pop) void'(q.pop_front());
            if (accepted) q.push_back(model_op(op, a, b, tg));
            m_rst = 1'b0;
        end
        armed = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit          acc;
        bit          r;
        bit          v;
        bit          ordy;
        logic [15:0] a;
        logic [15:0] b;
        n_tests = 0;
        n_fail  = 0;
        armed   = 1'b0;
        m_rst   = 1'b1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.in_tag    = 3'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with in_valid high, then released.
        step(0, 1, 2'd1, 16'hFFFF, 16'h1, 3'd7, 1, acc);
        step(0, 1, 2'd1, 16'hFFFF, 16'h1, 3'd7, 1, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);

        // All four ops back-to-back with out_ready high.
        for (int i = 0; i < 4; i++)
            step(1, 1, 2'(i), 16'hF0F0, 16'hFF00, 3'(i), 1, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);

        // Zero flag.
        step(1, 1, 2'd2, 16'h1234, 16'h1234, 3'd5, 1, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);

        // Backpressure: three ops against a stalled sink, then drain.
        for (int i = 0; i < 3; i++)
            step(1, 1, 2'(i), 16'hA5C3 + 16'(i), 16'h3C5A, 3'(i + 1), 0, acc);
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++)
            step(1, 1, 2'd2, 16'hA5C5, 16'h3C5A, 3'd3, 1, acc);
        check("bp_third_accepted", {31'h0, acc}, 32'h1);
        for (int i = 0; i < 3; i++)
            step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);

        // Accept and pop together in ONE for eight cycles.
        for (int i = 0; i < 8; i++)
            step(1, 1, 2'(i), 16'(16'h1111 * i), 16'h0F0F, 3'(i), 1, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);

        // Fill to FULL, pulse reset, then run a fresh op.
        step(1, 1, 2'd1, 16'h00FF, 16'h0F00, 3'd1, 0, acc);
        step(1, 1, 2'd0, 16'h00FF, 16'h0F00, 3'd2, 0, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 0, acc);
        step(0, 0, 2'd0, 16'h0, 16'h0, 3'd0, 0, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);
        step(1, 1, 2'd3, 16'hBEEF, 16'h00FF, 3'd6, 1, acc);
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);

        // Random traffic with occasional resets and frequent zero results.
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 59) != 0);
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            a    = 16'($urandom);
            b    = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            step(r, v, 2'($urandom_range(0, 3)), a, b, 3'($urandom_range(0, 7)), ordy, acc);
        end
        step(1, 0, 2'd0, 16'h0, 16'h0, 3'd0, 1, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
